lcd_hex_writer: RTL and testbench
=================================

// Module: lcd_hex_writer
// PURPOSE
//  Consumer end of the menu controller's lcd_data/lcd_data_valid stream. Buffers incoming bytes in a small FIFO,
//  runs the HD44780 power-up init sequence, then renders each byte as two ASCII hex characters at
//  DDRAM address 0x00 (line 1, cols 0-1) over an 8-bit parallel LCD bus with cycle-counted timing.
// PARAMETERS
//  FIFO_DEPTH     4       entries in input FIFO (power of 2)
//  FIFO_AW        2       log2(FIFO_DEPTH)
//  T_POWERUP_CYC  750000  cycles to wait after reset before first command (15 ms @ 50 MHz)
//  T_EN_HIGH_CYC  12      cycles lcd_e held high per write
//  T_CMD_CYC      2500    cycles to wait after lcd_e falls, normal command/data
//  T_CLEAR_CYC    82000   cycles to wait after lcd_e falls for clear (0x01)
// PORTS
//  clk             in   1  system clock; single clock domain
//  rst             in   1  reset, synchronous, active-high
//  lcd_data        in   8  byte to display
//  lcd_data_valid  in   1  1-cycle strobe qualifying lcd_data; no backpressure
//  busy            out  1  1 while init running, FIFO non-empty or a write sequence in flight
//  init_done       out  1  1 once init sequence completed; stays 1 until rst
//  overflow        out  1  1-cycle pulse when a strobe is dropped due to full FIFO
//  lcd_rs          out  1  LCD register select (0 cmd, 1 data)
//  lcd_rw          out  1  LCD read/write; constant 0
//  lcd_e           out  1  LCD enable strobe
//  lcd_db          out  8  LCD data bus
// BEHAVIOUR
//  Reset: rst sampled at clk edge; next cycle lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, init_done=0,
//   overflow=0, busy=1, FIFO emptied, FSM=PWRUP, counters 0. rst mid-operation aborts any write immediately.
//  FIFO: push when lcd_data_valid=1 and FIFO not full (full = pre-edge count == FIFO_DEPTH); a push attempt
//   while full drops the byte and pulses overflow next cycle, even if a pop occurs in the same cycle.
//   Push accepted during init. Simultaneous push+pop on non-full FIFO: both take effect, count unchanged.
//  Write primitive (one LCD byte): SETUP 1 cycle (rs/db driven, e=0) -> EHIGH T_EN_HIGH_CYC cycles (e=1) ->
//   WAIT T_CMD_CYC cycles, or T_CLEAR_CYC if cmd 0x01 (e=0). rs/db hold last value until next SETUP.
//  FSM: PWRUP (wait T_POWERUP_CYC) -> INIT writes, rs=0, in order 0x38,0x38,0x38,0x0C,0x06,0x01 ->
//   init_done=1 -> IDLE. IDLE: if FIFO non-empty, POP (latch head byte) -> write 0x80 rs=0 ->
//   write hex(byte[7:4]) rs=1 -> write hex(byte[3:0]) rs=1 -> IDLE.
//  Hex map: nibble 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (upper case).
//  Latency: byte strobed at edge N into empty FIFO with FSM in IDLE: POP at N+1, SETUP (db=0x80) at N+2,
//   lcd_e rises at N+3.
//  busy = (state != IDLE) | FIFO non-empty, registered; deasserts the cycle after last WAIT ends with FIFO empty.
//  Counters sized for largest T_*; each T_* >= 1. No wrap: counters reload on every state entry.
// TESTING (bench params: T_POWERUP_CYC=20, T_EN_HIGH_CYC=2, T_CMD_CYC=5, T_CLEAR_CYC=10)
//  1 rst 3 cycles, no input -> exactly 6 lcd_e pulses, rs=0, db 38,38,38,0C,06,01; init_done=1 10 cycles after last e fall; busy=0.
//  2 after init, strobe 0x2A -> e pulses with (rs,db) = (0,0x80),(1,0x32),(1,0x41); lcd_e rises 3 cycles after strobe edge.
//  3 strobe 0x00 then 0xFF back-to-back -> (0,80),(1,30),(1,30) then (0,80),(1,46),(1,46), in order, no overflow.
//  4 6 consecutive strobes 0x01..0x06 during PWRUP -> overflow pulses on 5th and 6th; after init only 01..04 rendered.
//  5 rst asserted during EHIGH of hex-high write -> next cycle e=0, db=0, init_done=0, busy=1; FIFO empty; init replays.
//  6 timing check all writes: e high exactly 2 cycles, e-fall to next e-rise = 5+1 cycles (10+1 after 0x01); lcd_rw always 0.

Source files
------------

// File: rtl/lcd_hex_writer.sv
// Drains a byte stream into an HD44780 LCD: power-up init, then each byte is shown
// as two upper-case hex characters at DDRAM 0x00 over an 8-bit bus with counted timing.
module lcd_hex_writer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int FIFO_AW       = 2,
  parameter int T_POWERUP_CYC = 750000,
  parameter int T_EN_HIGH_CYC = 12,
  parameter int T_CMD_CYC     = 2500,
  parameter int T_CLEAR_CYC   = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lcd_data,
  input  logic       lcd_data_valid,
  output logic       busy,
  output logic       init_done,
  output logic       overflow,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  localparam int T_MAX_A = (T_POWERUP_CYC > T_EN_HIGH_CYC) ? T_POWERUP_CYC : T_EN_HIGH_CYC;
  localparam int T_MAX_B = (T_CMD_CYC > T_CLEAR_CYC) ? T_CMD_CYC : T_CLEAR_CYC;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_SETUP, S_EHIGH, S_WAIT, S_IDLE, S_POP
  } state_t;

  // Write steps 0-5 are the init commands, 6 is the address set, 7/8 the two hex digits.
  localparam logic [3:0] SEQ_LAST_INIT = 4'd5;
  localparam logic [3:0] SEQ_ADDR      = 4'd6;
  localparam logic [3:0] SEQ_LAST_DATA = 4'd8;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, lim;
  logic [3:0]        seq_q, seq_d;
  logic              rs_q, rs_d;
  logic [7:0]        db_q, db_d;
  logic [7:0]        byte_q, byte_d;
  logic              init_done_q, init_done_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              pop;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full, push;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  function automatic logic [8:0] step_word(input logic [3:0] seq, input logic [7:0] b);
    case (seq)
      4'd0, 4'd1, 4'd2: return {1'b0, 8'h38};
      4'd3:             return {1'b0, 8'h0C};
      4'd4:             return {1'b0, 8'h06};
      4'd5:             return {1'b0, 8'h01};
      4'd6:             return {1'b0, 8'h80};
      4'd7:             return {1'b1, hex_char(b[7:4])};
      4'd8:             return {1'b1, hex_char(b[3:0])};
      default:          return 9'h000;
    endcase
  endfunction

  assign full = (count_q == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign push = lcd_data_valid & ~full;

  // Dwell length of the current state; the clear command needs the long wait.
  always_comb begin
    lim = CW'(1);
    case (state_q)
      S_PWRUP: lim = CW'(T_POWERUP_CYC);
      S_EHIGH: lim = CW'(T_EN_HIGH_CYC);
      S_WAIT:  lim = (!rs_q && db_q == 8'h01) ? CW'(T_CLEAR_CYC) : CW'(T_CMD_CYC);
      default: lim = CW'(1);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    rs_d        = rs_q;
    db_d        = db_q;
    byte_d      = byte_q;
    init_done_d = init_done_q;
    pop         = 1'b0;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == lim - CW'(1)) begin
          state_d = S_SETUP;
          seq_d   = 4'd0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETUP: begin
        state_d = S_EHIGH;
        cnt_d   = '0;
      end
      S_EHIGH: begin
        if (cnt_q == lim - CW'(1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == lim - CW'(1)) begin
          cnt_d = '0;
          if (seq_q == SEQ_LAST_INIT) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else if (seq_q == SEQ_LAST_DATA) begin
            state_d = S_IDLE;
          end else begin
            seq_d   = seq_q + 4'd1;
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          byte_d  = mem_q[rd_ptr_q];
          state_d = S_POP;
        end
      end
      S_POP: begin
        seq_d   = SEQ_ADDR;
        state_d = S_SETUP;
      end
      default: state_d = S_PWRUP;
    endcase
    // rs/db change only on SETUP entry and hold through the rest of the write.
    if (state_d == S_SETUP) {rs_d, db_d} = step_word(seq_d, byte_d);
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    overflow_d = lcd_data_valid & full;
    busy_d     = (state_d != S_IDLE) | (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= lcd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      seq_q       <= '0;
      rs_q        <= 1'b0;
      db_q        <= 8'h00;
      byte_q      <= 8'h00;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      rs_q        <= rs_d;
      db_q        <= db_d;
      byte_q      <= byte_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
    end
  end

  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign overflow  = overflow_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = (state_q == S_EHIGH);
  assign lcd_db    = db_q;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Directed bench for lcd_hex_writer: init sequence, hex rendering table,
// FIFO overflow during power-up, reset abort and LCD strobe timing.
module tb_lcd_hex_writer;

  localparam int T_PU  = 20;
  localparam int T_EN  = 2;
  localparam int T_CMD = 5;
  localparam int T_CLR = 10;

  logic       clk, rst, lcd_data_valid;
  logic [7:0] lcd_data;
  logic       busy, init_done, overflow, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  lcd_hex_writer #(
    .FIFO_DEPTH(4), .FIFO_AW(2), .T_POWERUP_CYC(T_PU),
    .T_EN_HIGH_CYC(T_EN), .T_CMD_CYC(T_CMD), .T_CLEAR_CYC(T_CLR)
  ) dut (
    .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_data_valid(lcd_data_valid),
    .busy(busy), .init_done(init_done), .overflow(overflow),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;
  vec_t vecs[8];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b1;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int rise_cyc, fall_cyc;
  bit have_rise, have_fall, last_clear, prev_e;
  int rw_bad = 0;
  int ovf_total = 0;

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_at_edge = rst;
  end

  // Bus monitor: records each write and checks strobe width and spacing.
  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_bad++;
    if (overflow === 1'b1) ovf_total++;
    if (rst_at_edge) begin
      have_rise = 1'b0;
      have_fall = 1'b0;
      prev_e    = 1'b0;
    end else begin
      if (lcd_e === 1'b1 && !prev_e) begin
        got_q.push_back({lcd_rs, lcd_db});
        if (have_fall && !(lcd_rs == 1'b0 && lcd_db == 8'h80))
          check("e_gap", cyc - fall_cyc, last_clear ? T_CLR + 1 : T_CMD + 1);
        rise_cyc   = cyc;
        have_rise  = 1'b1;
        last_clear = (lcd_rs == 1'b0 && lcd_db == 8'h01);
      end else if (lcd_e === 1'b0 && prev_e) begin
        if (have_rise) check("e_high", cyc - rise_cyc, T_EN);
        fall_cyc  = cyc;
        have_fall = 1'b1;
      end
      prev_e = (lcd_e === 1'b1);
    end
  end

  // driver tasks
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d, output int at);
    lcd_data       = d;
    lcd_data_valid = 1'b1;
    @(negedge clk);
    at             = cyc;
    lcd_data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 600);
    check("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask

  task automatic push_byte(input vec_t v);
    exp_q.push_back(9'h080);
    exp_q.push_back({1'b1, v.hi});
    exp_q.push_back({1'b1, v.lo});
  endtask

  // scoreboard
  task automatic check_writes(input string name);
    logic [8:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 9'h1FF;
      check(name, {23'd0, g}, {23'd0, e});
    end
    check({name, "_extra"}, got_q.size(), 0);
    got_q.delete();
  endtask

  initial begin
    int t, n, t_done, ov0;
    vecs[0] = '{8'h2A, 8'h32, 8'h41};
    vecs[1] = '{8'h00, 8'h30, 8'h30};
    vecs[2] = '{8'hFF, 8'h46, 8'h46};
    vecs[3] = '{8'h9B, 8'h39, 8'h42};
    vecs[4] = '{8'h5C, 8'h35, 8'h43};
    vecs[5] = '{8'hE7, 8'h45, 8'h37};
    vecs[6] = '{8'h4D, 8'h34, 8'h44};
    vecs[7] = '{8'h10, 8'h31, 8'h30};
    rst            = 1'b1;
    lcd_data       = 8'h00;
    lcd_data_valid = 1'b0;

    // Reset state and power-up init sequence
    do_reset(3);
    check("rst_e", lcd_e, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_db", lcd_db, 8'h00);
    check("rst_init_done", init_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 1);
    got_q.delete();
    push_init();
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    t_done = cyc;
    check("init_done_seen", init_done, 1);
    check("init_done_delay", t_done - fall_cyc, T_CLR);
    wait_idle();
    check_writes("init_seq");
    check("init_done_hold", init_done, 1);

    // Single byte with latency from strobe edge to lcd_e rise
    strobe(vecs[0].data, t);
    n = 0;
    while (lcd_e !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("e_latency", cyc - t, 3);
    push_byte(vecs[0]);
    wait_idle();
    check_writes("byte_2A");

    // Back-to-back strobes 0x00, 0xFF
    ov0            = ovf_total;
    lcd_data       = vecs[1].data;
    lcd_data_valid = 1'b1;
    @(negedge clk);
    lcd_data       = vecs[2].data;
    @(negedge clk);
    lcd_data_valid = 1'b0;
    push_byte(vecs[1]);
    push_byte(vecs[2]);
    wait_idle();
    check_writes("b2b");
    check("b2b_no_ovf", ovf_total - ov0, 0);

    // Hex map table
    for (int i = 3; i < 8; i++) begin
      strobe(vecs[i].data, t);
      push_byte(vecs[i]);
      wait_idle();
      check_writes("hex_table");
    end

    // Six strobes during power-up: FIFO holds four, last two overflow
    do_reset(1);
    got_q.delete();
    ov0 = ovf_total;
    for (int i = 0; i < 6; i++) begin
      lcd_data       = 8'(i + 1);
      lcd_data_valid = 1'b1;
      @(negedge clk);
      check("ovf_pulse", overflow, (i >= 4) ? 1 : 0);
    end
    lcd_data_valid = 1'b0;
    push_init();
    exp_q.push_back(9'h080); exp_q.push_back(9'h130); exp_q.push_back(9'h131);
    exp_q.push_back(9'h080); exp_q.push_back(9'h130); exp_q.push_back(9'h132);
    exp_q.push_back(9'h080); exp_q.push_back(9'h130); exp_q.push_back(9'h133);
    exp_q.push_back(9'h080); exp_q.push_back(9'h130); exp_q.push_back(9'h134);
    wait_idle();
    check_writes("pwrup_fill");
    check("ovf_count", ovf_total - ov0, 2);

    // Reset during the high-digit strobe, with a second byte queued
    lcd_data       = 8'h3C;
    lcd_data_valid = 1'b1;
    @(negedge clk);
    lcd_data       = 8'h5A;
    @(negedge clk);
    lcd_data_valid = 1'b0;
    n = 0;
    while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hex_hi_strobe_seen", {lcd_e, lcd_rs, lcd_db}, {2'b11, 8'h33});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_e", lcd_e, 0);
    check("abort_rs", lcd_rs, 0);
    check("abort_db", lcd_db, 8'h00);
    check("abort_init_done", init_done, 0);
    check("abort_busy", busy, 1);
    got_q.delete();
    push_init();
    wait_idle();
    check_writes("init_replay");

    check("rw_always_0", rw_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
